// File: rtl/sensor_seq_gen_pkg.sv
// Shared encodings for the two-sensor pass generator: FSM states, x1/x2 phase
// patterns and direction codes.
package sensor_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    BOTH  = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Patterns are packed as {x1, x2}
  localparam logic [1:0] PAT_IDLE = 2'b00;
  localparam logic [1:0] PAT_BOTH = 2'b11;
  localparam logic [1:0] PAT_X1   = 2'b10;
  localparam logic [1:0] PAT_X2   = 2'b01;

  localparam logic DIR_X1_FIRST = 1'b0;
  localparam logic DIR_X2_FIRST = 1'b1;

  function automatic logic [1:0] lead_pat(input logic dir);
    return (dir == DIR_X1_FIRST) ? PAT_X1 : PAT_X2;
  endfunction

  function automatic logic [1:0] trail_pat(input logic dir);
    return (dir == DIR_X1_FIRST) ? PAT_X2 : PAT_X1;
  endfunction

endpackage

// File: rtl/sensor_seq_gen_phase_timer.sv
// Loadable down-counter timing one sensor phase; expire marks the final cycle
// of the phase (count == 1).
module phase_timer #(
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [HOLD_W-1:0] value,
  input  logic              en,
  output logic              expire
);

  logic [HOLD_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - HOLD_W'(1);
    end
  end

  assign expire = (count == HOLD_W'(1));

endmodule

// File: rtl/sensor_seq_gen.sv
// Emits one x1/x2 vehicle-pass waveform per start request (LEAD, BOTH, TRAIL,
// GAP, each H cycles), with abort and a running count of completed passes.
module sensor_seq_gen
  import sensor_seq_pkg::*;
#(
  parameter int HOLD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [HOLD_W-1:0] hold,
  input  logic              abort,
  output logic              x1,
  output logic              x2,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  pass_cnt
);

  state_t            state;
  logic              dir_r;
  logic [HOLD_W-1:0] h_r;
  logic [HOLD_W-1:0] h_in;
  logic              accept;
  logic              in_phase;
  logic              expire;
  logic              t_load;
  logic [HOLD_W-1:0] t_value;

  always_comb begin
    h_in     = (hold == '0) ? HOLD_W'(1) : hold;
    in_phase = (state == LEAD) || (state == BOTH) || (state == TRAIL) || (state == GAP);
    accept   = ((state == IDLE) || (state == DONE)) && start && !abort;
    // Reload on every phase entry; GAP exits to DONE so it needs no reload.
    t_load   = accept || (in_phase && !abort && expire && (state != GAP));
    t_value  = accept ? h_in : h_r;
  end

  phase_timer #(
    .HOLD_W(HOLD_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (t_load),
    .value  (t_value),
    .en     (in_phase),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dir_r    <= DIR_X1_FIRST;
      h_r      <= HOLD_W'(1);
      {x1, x2} <= PAT_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      pass_cnt <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            dir_r    <= dir;
            h_r      <= h_in;
            state    <= LEAD;
            {x1, x2} <= lead_pat(dir);
            busy     <= 1'b1;
          end else begin
            state    <= IDLE;
            {x1, x2} <= PAT_IDLE;
            busy     <= 1'b0;
          end
        end
        LEAD, BOTH, TRAIL, GAP: begin
          if (abort) begin
            state    <= IDLE;
            {x1, x2} <= PAT_IDLE;
            busy     <= 1'b0;
            aborted  <= 1'b1;
          end else if (expire) begin
            case (state)
              LEAD: begin
                state    <= BOTH;
                {x1, x2} <= PAT_BOTH;
              end
              BOTH: begin
                state    <= TRAIL;
                {x1, x2} <= trail_pat(dir_r);
              end
              TRAIL: begin
                state    <= GAP;
                {x1, x2} <= PAT_IDLE;
              end
              default: begin
                state    <= DONE;
                {x1, x2} <= PAT_IDLE;
                busy     <= 1'b0;
                done     <= 1'b1;
                pass_cnt <= pass_cnt + CNT_W'(1);
              end
            endcase
          end
        end
        default: begin
          state    <= IDLE;
          {x1, x2} <= PAT_IDLE;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Phase changes move one sensor at a time; only abort or reset may drop both.
  a_one_bit_step: assert property (@(posedge clk) disable iff (rst)
    (!aborted && !$past(rst)) |-> ($countones({x1, x2} ^ $past({x1, x2})) <= 1));

  a_done_not_busy: assert property (@(posedge clk) disable iff (rst)
    !(done && (busy || aborted)));

endmodule

// File: doc/sensor_seq_gen.md
Name: sensor_seq_gen

Overview:
- Generates the two-sensor (x1, x2) waveform that a vehicle produces when it passes a pair of gate sensors in a commanded direction.
- This is the transmit-side counterpart of the direction-detecting FSM that consumes x1/x2.
- Drives the detector in system test and can replace the physical sensors in the traffic light controller test harness.
- Emits one complete pass per request, with a programmable hold time per phase, and keeps a running count of completed passes.

Parameters:
- HOLD_W, 8, width of the per-phase hold-count input.
- CNT_W, 8, width of the completed-pass counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request one pass; sampled only in IDLE or DONE.
- dir  in  1  0 = x1 leads (x1 side to x2 side); 1 = x2 leads; sampled with start.
- hold  in  HOLD_W  cycles per phase; sampled with start.
- abort  in  1  terminate the pass in progress.
- x1  out  1  sensor 1 output, registered.
- x2  out  1  sensor 2 output, registered.
- busy  out  1  high while a pass is being emitted.
- done  out  1  one-cycle pulse when a pass completes.
- aborted  out  1  one-cycle pulse when a pass is aborted.
- pass_cnt  out  CNT_W  number of completed passes.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; x1=0, x2=0, busy=0, done=0, aborted=0, pass_cnt=0. Reset overrides every other input, including mid-pass. A reset mid-pass does not pulse aborted.
- States and their outputs:
  - IDLE: {x1,x2}=00, busy=0.
  - LEAD: lead sensor only; dir=0 gives 10, dir=1 gives 01.
  - BOTH: 11.
  - TRAIL: trail sensor only; dir=0 gives 01, dir=1 gives 10.
  - GAP: 00, busy=1.
  - DONE: 00, busy=0, done=1 for exactly this one cycle.
- Start handling: start=1 in IDLE or DONE latches dir and hold into internal registers; the next cycle is LEAD. The latched hold is H = max(hold, 1), so hold=0 behaves as 1.
- Phase timing: LEAD, BOTH, TRAIL and GAP each last exactly H cycles, then advance in that order. After GAP the FSM enters DONE for 1 cycle, then IDLE, unless start is high in DONE, in which case it goes to LEAD (back-to-back passes).
- Latency: start seen at edge k gives LEAD outputs in cycle k+1 and the done pulse in cycle k+4H+1. Back-to-back passes therefore have a period of 4H+1 cycles.
- Invalid requests: start while busy=1 is ignored, and no latched value changes. dir and hold changes mid-pass have no effect.
- pass_cnt: increments by 1 in the DONE cycle, wraps modulo 2^CNT_W (255 to 0 at the default width), and never decrements.
- Abort:
  - abort=1 in LEAD/BOTH/TRAIL/GAP gives, next cycle: {x1,x2}=00, busy=0, aborted=1 (one cycle), state=IDLE. No done pulse and pass_cnt is unchanged.
  - abort in IDLE or DONE is ignored.
  - abort and start together in IDLE/DONE: start is ignored and the FSM stays/returns to IDLE.
- Output ordering: phase transitions never produce the 00 to 11 or 10 to 01 jumps. Consecutive outputs differ in exactly one bit, except on abort (any to 00).
- Illegal state encodings recover to IDLE on the next clock with outputs 00.

Decomposition:
- Shared package sensor_seq_pkg holds:
  - the state encoding constants: IDLE, LEAD, BOTH, TRAIL, GAP, DONE (3-bit);
  - the phase pattern constants: PAT_IDLE=00, PAT_BOTH=11, PAT_X1=10, PAT_X2=01;
  - DIR_X1_FIRST=0 and DIR_X2_FIRST=1.
- The detector block's own encoding stays separate.
- One natural sub-module: phase_timer, a HOLD_W-bit loadable down-counter.
  - Inputs: load, value, en.
  - Output: expire, asserted when the count reaches 1.
  - Reloaded on every phase entry.

Test Plan:
- Reset then idle, rst high for 2 cycles with start=1 held: x1=x2=0, busy=0, pass_cnt=0, no done.
- start=1, dir=0, hold=3 at edge k: {x1,x2}=10 in cycles k+1..k+3, 11 in k+4..k+6, 01 in k+7..k+9, 00 in k+10..k+12, done=1 in k+13 only, pass_cnt=1, busy high in k+1..k+12.
- start=1, dir=1, hold=0: 01, 11, 10, 00 for 1 cycle each, done in k+5, pass_cnt=1; a further start=1 during BOTH is ignored.
- Back-to-back, start held high with dir=0, hold=2: done pulses every 9 cycles, LEAD immediately follows DONE, and pass_cnt counts 1, 2, 3.
- Abort, dir=0, hold=4, abort=1 in the 2nd BOTH cycle: next cycle 00, aborted=1, busy=0, no done, pass_cnt unchanged; abort+start together in IDLE results in no pass.
- Wrap and reset mid-pass: preload 255 completed passes, and the next pass makes pass_cnt=0. Asserting rst during TRAIL gives all outputs 0 the next cycle, pass_cnt=0 and no aborted pulse.
